// File: rtl/alu_pkg.sv
// Shared constants for the two-operand ALU: operation encodings and default width.
package alu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_AND = 1'b1;

endpackage

// File: rtl/alu_core.sv
// Combinational ADD/AND datapath; carry is the top bit of the widened sum.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  logic             sel,
  output logic [WIDTH-1:0] zout,
  output logic             cout
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, ain} + {1'b0, bin};

  always_comb begin
    zout = '0;
    cout = 1'b0;
    unique case (sel)
      OP_ADD: {cout, zout} = sum;
      OP_AND: zout = ain & bin;
      default: begin
        zout = '0;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_unit.sv
// ALU top: combinational result plus a one-cycle registered copy with zero and valid flags.
module alu_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  logic             sel,
  output logic [WIDTH-1:0] zout,
  output logic             cout,
  output logic [WIDTH-1:0] zout_q,
  output logic             cout_q,
  output logic             zero_q,
  output logic             valid_q
);

  logic zero_d;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .ain (ain),
    .bin (bin),
    .sel (sel),
    .zout(zout),
    .cout(cout)
  );

  assign zero_d = (zout == '0);

  // Reset only touches the pipeline copy; zout/cout stay purely combinational.
  always_ff @(posedge clk) begin
    if (rst) begin
      zout_q  <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      zout_q  <= zout;
      cout_q  <= cout;
      zero_q  <= zero_d;
      valid_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: vector table, exhaustive sweep and reset corner cases.
module tb_alu_unit;

  logic       clk;
  logic       rst;
  logic [1:0] ain;
  logic [1:0] bin;
  logic       sel;
  logic [1:0] zout;
  logic       cout;
  logic [1:0] zout_q;
  logic       cout_q;
  logic       zero_q;
  logic       valid_q;

  int checks;
  int failures;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic       s;
    logic [1:0] ez;
    logic       ec;
  } vec_t;

  typedef struct {
    logic [1:0] z;
    logic       c;
    logic       zero;
  } exp_t;

  exp_t sb[$];

  alu_unit #(
    .WIDTH(2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ain    (ain),
    .bin    (bin),
    .sel    (sel),
    .zout   (zout),
    .cout   (cout),
    .zout_q (zout_q),
    .cout_q (cout_q),
    .zero_q (zero_q),
    .valid_q(valid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one operation with rst low, check combinational outputs, queue the registered expectation.
  task automatic apply(input logic [1:0] a, input logic [1:0] b, input logic s,
                       input logic [1:0] ez, input logic ec);
    exp_t e;
    ain = a;
    bin = b;
    sel = s;
    rst = 1'b0;
    #1;
    check("zout", 32'(zout), 32'(ez));
    check("cout", 32'(cout), 32'(ec));
    e.z    = ez;
    e.c    = ec;
    e.zero = (ez == 2'd0);
    sb.push_back(e);
  endtask

  task automatic clock_and_compare();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      check("zout_q", 32'(zout_q), 32'(e.z));
      check("cout_q", 32'(cout_q), 32'(e.c));
      check("zero_q", 32'(zero_q), 32'(e.zero));
      check("valid_q", 32'(valid_q), 32'd1);
    end
  endtask

  initial begin
    vec_t vecs[9];
    checks   = 0;
    failures = 0;

    vecs[0] = '{a: 2'd3, b: 2'd2, s: 1'b1, ez: 2'd2, ec: 1'b0};
    vecs[1] = '{a: 2'd1, b: 2'd2, s: 1'b1, ez: 2'd0, ec: 1'b0};
    vecs[2] = '{a: 2'd1, b: 2'd3, s: 1'b1, ez: 2'd1, ec: 1'b0};
    vecs[3] = '{a: 2'd2, b: 2'd1, s: 1'b1, ez: 2'd0, ec: 1'b0};
    vecs[4] = '{a: 2'd3, b: 2'd1, s: 1'b0, ez: 2'd0, ec: 1'b1};
    vecs[5] = '{a: 2'd1, b: 2'd3, s: 1'b0, ez: 2'd0, ec: 1'b1};
    vecs[6] = '{a: 2'd3, b: 2'd2, s: 1'b0, ez: 2'd1, ec: 1'b1};
    vecs[7] = '{a: 2'd1, b: 2'd0, s: 1'b0, ez: 2'd1, ec: 1'b0};
    vecs[8] = '{a: 2'd1, b: 2'd1, s: 1'b0, ez: 2'd2, ec: 1'b0};

    // Reset state
    rst = 1'b1;
    ain = 2'd0;
    bin = 2'd0;
    sel = 1'b0;
    @(posedge clk);
    #1;
    check("rst zout_q", 32'(zout_q), 32'd0);
    check("rst cout_q", 32'(cout_q), 32'd0);
    check("rst zero_q", 32'(zero_q), 32'd1);
    check("rst valid_q", 32'(valid_q), 32'd0);

    // Table vectors, each followed by its registered check one edge later
    for (int i = 0; i < 9; i++) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].ez, vecs[i].ec);
      clock_and_compare();
    end

    // Register latency: 1+1 then 3+1 back to back
    apply(2'd1, 2'd1, 1'b0, 2'd2, 1'b0);
    clock_and_compare();
    apply(2'd3, 2'd1, 1'b0, 2'd0, 1'b1);
    clock_and_compare();

    // Reset mid-stream: zout follows inputs, registers are forced
    ain = 2'd3;
    bin = 2'd2;
    sel = 1'b1;
    rst = 1'b1;
    #1;
    check("mid-rst zout", 32'(zout), 32'd2);
    check("mid-rst cout", 32'(cout), 32'd0);
    @(posedge clk);
    #1;
    check("mid-rst zout_q", 32'(zout_q), 32'd0);
    check("mid-rst cout_q", 32'(cout_q), 32'd0);
    check("mid-rst zero_q", 32'(zero_q), 32'd1);
    check("mid-rst valid_q", 32'(valid_q), 32'd0);
    check("mid-rst zout hold", 32'(zout), 32'd2);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post-rst zout_q", 32'(zout_q), 32'd2);
    check("post-rst zero_q", 32'(zero_q), 32'd0);
    check("post-rst valid_q", 32'(valid_q), 32'd1);

    // Exhaustive sweep against an integer reference model
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 4; a++) begin
        for (int b = 0; b < 4; b++) begin
          int sum;
          logic [1:0] ez;
          logic ec;
          sum = a + b;
          if (s == 1) begin
            ez = 2'(a & b);
            ec = 1'b0;
          end else begin
            ez = 2'(sum % 4);
            ec = (sum >= 4);
          end
          apply(2'(a), 2'(b), 1'(s), ez, ec);
          clock_and_compare();
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
